// File: rtl/xcorr_scheduler.sv
// Frame sequencer: for each mic pair runs xcorr then argmax, collects lag/peak,
// and publishes a complete result set before releasing the ping-pong reader.
module xcorr_scheduler #(
   parameter int NPAIRS  = 3,
   parameter int IDX_W   = 9,
   parameter int MAX_W   = 17,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      frame_ready,
   output logic                      read_done,
   output logic [1:0]                pair_sel,
   output logic                      xc_start,
   input  logic                      xc_valid,
   output logic                      am_start,
   input  logic                      am_valid,
   input  logic [IDX_W-1:0]          am_index,
   input  logic [MAX_W-1:0]          am_max,
   output logic [NPAIRS*IDX_W-1:0]   lags,
   output logic [1:0]                best_pair,
   output logic                      result_valid,
   output logic                      frame_err,
   output logic                      busy,
   output logic [7:0]                frame_count
);

   localparam int         TMR_W     = $clog2(TIMEOUT);
   localparam logic [1:0] LAST_PAIR = 2'(NPAIRS - 1);

   typedef enum logic [3:0] {
      IDLE, XC_START, XC_WAIT, AM_START, AM_WAIT, STORE, NEXT, PUBLISH, RELEASE
   } state_t;

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic               xc_valid_d;
   logic               am_valid_d;
   logic [IDX_W-1:0]   work_lag [NPAIRS];
   logic [1:0]         work_best;
   logic [MAX_W-1:0]   best_max;

   logic                     in_wait;
   logic                     wait_rise;
   logic                     timed_out;
   logic                     last_done;
   logic                     publish;
   logic [NPAIRS*IDX_W-1:0]  pub_lags;

   // The result set is loaded on entry to PUBLISH so result_valid and the new
   // lags appear together; an aborted frame marks the unfinished pairs all-ones.
   always_comb begin
      in_wait   = (state == XC_WAIT) || (state == AM_WAIT);
      wait_rise = (state == XC_WAIT) ? (xc_valid & ~xc_valid_d)
                                     : (am_valid & ~am_valid_d);
      timed_out = in_wait && !wait_rise && (timer == TMR_W'(TIMEOUT - 1));
      last_done = (state == NEXT) && (pair_sel == LAST_PAIR);
      publish   = timed_out || last_done;
      for (int p = 0; p < NPAIRS; p++) begin
         pub_lags[p*IDX_W +: IDX_W] = (timed_out && (p >= int'(pair_sel))) ? '1 : work_lag[p];
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state        <= IDLE;
         read_done    <= 1'b1;
         pair_sel     <= '0;
         xc_start     <= 1'b0;
         am_start     <= 1'b0;
         result_valid <= 1'b0;
         lags         <= '0;
         best_pair    <= '0;
         frame_err    <= 1'b0;
         frame_count  <= '0;
         timer        <= '0;
         xc_valid_d   <= 1'b0;
         am_valid_d   <= 1'b0;
         work_best    <= '0;
         best_max     <= '0;
         for (int p = 0; p < NPAIRS; p++) work_lag[p] <= '0;
      end else begin
         xc_valid_d   <= xc_valid;
         am_valid_d   <= am_valid;
         xc_start     <= 1'b0;
         am_start     <= 1'b0;
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               read_done <= 1'b1;
               if (frame_ready) begin
                  pair_sel  <= '0;
                  read_done <= 1'b0;
                  work_best <= '0;
                  best_max  <= '0;
                  for (int p = 0; p < NPAIRS; p++) work_lag[p] <= '0;
                  state     <= XC_START;
               end
            end
            XC_START: begin
               xc_start <= 1'b1;
               timer    <= '0;
               state    <= XC_WAIT;
            end
            XC_WAIT: begin
               if (wait_rise) state <= AM_START;
               else           timer <= timer + 1'b1;
            end
            AM_START: begin
               am_start <= 1'b1;
               timer    <= '0;
               state    <= AM_WAIT;
            end
            AM_WAIT: begin
               if (wait_rise) state <= STORE;
               else           timer <= timer + 1'b1;
            end
            STORE: begin
               work_lag[pair_sel] <= am_index;
               // strict compare keeps the lower pair on ties
               if (am_max > best_max) begin
                  best_max  <= am_max;
                  work_best <= pair_sel;
               end
               state <= NEXT;
            end
            NEXT: begin
               if (!last_done) begin
                  pair_sel <= pair_sel + 2'd1;
                  state    <= XC_START;
               end
            end
            PUBLISH: state <= RELEASE;
            RELEASE: if (!frame_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (publish) begin
            lags         <= pub_lags;
            best_pair    <= work_best;
            frame_err    <= timed_out;
            frame_count  <= frame_count + 8'd1;
            result_valid <= 1'b1;
            read_done    <= 1'b1;
            state        <= PUBLISH;
         end
      end
   end

endmodule

// File: tb/tb_xcorr_scheduler.sv
// Bench for xcorr_scheduler: randomized xcorr/argmax responders plus a
// frame-level reference model checked against the outputs on every cycle.
module tb_xcorr_scheduler;

   localparam int NP  = 3;
   localparam int IW  = 9;
   localparam int MW  = 17;
   localparam int TO  = 4096;
   localparam int BIG = 1_000_000_000;

   logic              clk = 1'b0;
   logic              n_reset, frame_ready, xc_valid, am_valid;
   logic [IW-1:0]     am_index;
   logic [MW-1:0]     am_max;
   logic              read_done, xc_start, am_start, result_valid, frame_err, busy;
   logic [1:0]        pair_sel, best_pair;
   logic [NP*IW-1:0]  lags;
   logic [7:0]        frame_count;

   always #5 clk = ~clk;

   xcorr_scheduler #(.NPAIRS(NP), .IDX_W(IW), .MAX_W(MW), .TIMEOUT(TO)) dut (
      .clk(clk), .n_reset(n_reset), .frame_ready(frame_ready), .read_done(read_done),
      .pair_sel(pair_sel), .xc_start(xc_start), .xc_valid(xc_valid),
      .am_start(am_start), .am_valid(am_valid), .am_index(am_index), .am_max(am_max),
      .lags(lags), .best_pair(best_pair), .result_valid(result_valid),
      .frame_err(frame_err), .busy(busy), .frame_count(frame_count)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // frame configuration and reference model state
   logic [IW-1:0]    cfg_idx [NP];
   logic [MW-1:0]    cfg_max [NP];
   int               xc_dly [NP];
   int               am_dly [NP];
   int               hang_pair = -1;
   int               am_hang_pair = -1;
   bit               stale = 1'b0;
   int               fr_cyc = BIG, rv_cyc = BIG, drop_cyc = BIG;
   int               xc_rise_cyc = 0;
   int               xc_seen = 0, am_seen = 0, xp = 0, ap = 0, n = 0;
   bit               rv_seen = 1'b0, in_frame = 1'b0;
   logic [NP*IW-1:0] exp_lags = '0;
   logic [1:0]       exp_best = '0;
   logic             exp_err = 1'b0;
   logic [7:0]       exp_count = '0;
   bit               prev_xc = 1'b0, prev_am = 1'b0;
   bit               exp_busy, exp_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result of a frame: completed pairs report their lag, the rest all-ones;
   // best pair is the lowest-numbered completed pair holding the largest peak.
   function automatic void publish_model();
      int done;
      logic [MW-1:0] mx;
      done = (hang_pair >= 0) ? hang_pair : NP;
      mx = '0;
      for (int p = 0; p < done; p++) if (cfg_max[p] > mx) mx = cfg_max[p];
      exp_best = '0;
      for (int p = done - 1; p >= 0; p--) if (cfg_max[p] == mx) exp_best = 2'(p);
      for (int p = 0; p < NP; p++) exp_lags[p*IW +: IW] = (p < done) ? cfg_idx[p] : '1;
      exp_err   = (hang_pair >= 0);
      exp_count = exp_count + 8'd1;
   endfunction

   always begin
      @(posedge clk); #1;
      if (!n_reset) begin
         chk("rst_read_done", 32'(read_done), 1);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_lags", 32'(lags), 0);
         chk("rst_best_pair", 32'(best_pair), 0);
         chk("rst_frame_err", 32'(frame_err), 0);
         chk("rst_frame_count", 32'(frame_count), 0);
         chk("rst_pair_sel", 32'(pair_sel), 0);
         chk("rst_pulses", 32'({xc_start, am_start, result_valid}), 0);
      end else begin
         if (cyc == rv_cyc) begin
            publish_model();
            rv_seen  = 1'b1;
            in_frame = 1'b0;
         end
         exp_busy = (cyc > fr_cyc) && ((cyc <= drop_cyc) || (cyc <= rv_cyc + 1));
         exp_rd   = !((cyc > fr_cyc) && (cyc < rv_cyc));
         chk("result_valid", 32'(result_valid), 32'(cyc == rv_cyc));
         chk("lags", 32'(lags), 32'(exp_lags));
         chk("best_pair", 32'(best_pair), 32'(exp_best));
         chk("frame_err", 32'(frame_err), 32'(exp_err));
         chk("frame_count", 32'(frame_count), 32'(exp_count));
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("read_done", 32'(read_done), 32'(exp_rd));
         chk("xc_start_width", 32'(xc_start & prev_xc), 0);
         chk("am_start_width", 32'(am_start & prev_am), 0);
      end
      prev_xc = xc_start;
      prev_am = am_start;
   end

   // xcorr responder: valid drops after start, then rises after a delay
   always begin
      @(posedge clk); #1;
      if (n_reset && xc_start) begin
         xp = xc_seen;
         xc_seen++;
         chk("xc_start_in_frame", 32'(in_frame), 1);
         chk("xc_pair_sel", 32'(pair_sel), xp);
         if (xp == 0) chk("xc_start_latency", cyc - fr_cyc, 2);
         if (xp == hang_pair) rv_cyc = cyc + TO;
         @(negedge clk);
         if (stale) repeat (3) @(negedge clk);
         xc_valid = 1'b0;
         if (xp != hang_pair) begin
            repeat (xc_dly[xp % NP]) @(negedge clk);
            xc_valid    = 1'b1;
            xc_rise_cyc = cyc;
         end
      end
   end

   // argmax responder: presents index/peak with a fresh rising valid
   always begin
      @(posedge clk); #1;
      if (n_reset && am_start) begin
         ap = am_seen;
         am_seen++;
         chk("am_pair_sel", 32'(pair_sel), ap);
         chk("am_start_latency", cyc - xc_rise_cyc, 2);
         @(negedge clk);
         am_valid = 1'b0;
         if (ap != am_hang_pair) begin
            repeat (am_dly[ap % NP]) @(negedge clk);
            am_index = cfg_idx[ap % NP];
            am_max   = cfg_max[ap % NP];
            am_valid = 1'b1;
            if (ap == NP - 1) rv_cyc = cyc + 3;
         end
      end
   end

   task automatic rand_cfg();
      for (int p = 0; p < NP; p++) begin
         cfg_idx[p] = IW'($urandom_range(0, 511));
         cfg_max[p] = MW'($urandom_range(0, 3) * 40000);
         xc_dly[p]  = int'($urandom_range(1, 5));
         am_dly[p]  = int'($urandom_range(1, 5));
      end
   endtask

   task automatic start_frame();
      xc_seen = 0;
      am_seen = 0;
      rv_seen = 1'b0;
      @(negedge clk);
      rv_cyc      = BIG;
      drop_cyc    = BIG;
      fr_cyc      = cyc;
      in_frame    = 1'b1;
      frame_ready = 1'b1;
   endtask

   task automatic run_frame(input int hold);
      int k;
      start_frame();
      k = 0;
      while (!rv_seen && k < 6000) begin
         @(negedge clk);
         k++;
      end
      chk("frame_done", 32'(rv_seen), 1);
      repeat (hold) @(negedge clk);
      frame_ready = 1'b0;
      drop_cyc    = cyc;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      chk("xc_start_count", xc_seen, (hang_pair >= 0) ? hang_pair + 1 : NP);
      chk("am_start_count", am_seen, (hang_pair >= 0) ? hang_pair : NP);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_reset = 1'b0; frame_ready = 1'b0; xc_valid = 1'b0; am_valid = 1'b0;
      am_index = '0; am_max = '0;
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      repeat (2) @(negedge clk);

      // fixed frame with a peak tie between pairs 1 and 2
      cfg_idx[0] = 9'd5;   cfg_max[0] = 17'd100;
      cfg_idx[1] = 9'd17;  cfg_max[1] = 17'd900;
      cfg_idx[2] = 9'd300; cfg_max[2] = 17'd900;
      for (int p = 0; p < NP; p++) begin xc_dly[p] = 2; am_dly[p] = 2; end
      run_frame(2);
      chk("t1_lags", 32'(lags), 32'({9'd300, 9'd17, 9'd5}));
      chk("t1_best_pair", 32'(best_pair), 1);
      chk("t1_frame_count", 32'(frame_count), 1);
      chk("t1_frame_err", 32'(frame_err), 0);

      // frame_ready held long after publish: no second frame
      rand_cfg();
      run_frame(20);
      chk("t6_frame_count", 32'(frame_count), 2);

      // xc_valid left high from the previous pair
      rand_cfg();
      stale = 1'b1;
      run_frame(2);
      stale = 1'b0;
      chk("t3_frame_count", 32'(frame_count), 3);

      // pair 1 xcorr never completes
      rand_cfg();
      cfg_idx[0] = 9'd42;
      cfg_max[0] = 17'd500;
      hang_pair  = 1;
      run_frame(2);
      hang_pair  = -1;
      chk("t4_lag0", 32'(lags[8:0]), 32'h2A);
      chk("t4_lag12", 32'(lags[26:9]), 32'h3FFFF);
      chk("t4_best_pair", 32'(best_pair), 0);
      chk("t4_frame_err", 32'(frame_err), 1);

      // reset while waiting on argmax of pair 2
      rand_cfg();
      am_hang_pair = 2;
      start_frame();
      n = 0;
      while (am_seen < NP && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reached_am_wait", am_seen, NP);
      repeat (3) @(negedge clk);
      n_reset = 1'b0; frame_ready = 1'b0; xc_valid = 1'b0; am_valid = 1'b0;
      fr_cyc = BIG; rv_cyc = BIG; drop_cyc = BIG; in_frame = 1'b0;
      exp_lags = '0; exp_best = '0; exp_err = 1'b0; exp_count = '0;
      repeat (3) @(negedge clk);
      chk("t5_read_done", 32'(read_done), 1);
      chk("t5_lags", 32'(lags), 0);
      chk("t5_busy", 32'(busy), 0);
      n_reset = 1'b1;
      am_hang_pair = -1;
      repeat (2) @(negedge clk);
      rand_cfg();
      run_frame(1);
      chk("t5_next_frame_count", 32'(frame_count), 1);

      // randomized frames through the frame_count wrap
      for (int f = 0; f < 255; f++) begin
         rand_cfg();
         run_frame(int'($urandom_range(1, 3)));
      end
      chk("wrap_frame_count", 32'(frame_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
